// File: rtl/icestick_afifo_producer_pkg.sv
// Shared constants for the synthetic pixel producer: FSM encoding, LFSR taps/seed, counter sizing.
// The LFSR pattern is selected in the top module by defining PRODUCER_LFSR_EN.
package producer_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_HBLANK = 2'd1,
    ST_VBLANK = 2'd2
  } state_e;

  // x^12+x^11+x^10+x^4+1 -> feedback from bits 11,10,9,3 (shift toward MSB)
  localparam logic [11:0] LFSR_TAPS = 12'hE08;
  localparam logic [11:0] LFSR_SEED = 12'h001;

  function automatic logic [11:0] lfsr_step(input logic [11:0] s);
    return {s[10:0], ^(s & LFSR_TAPS)};
  endfunction

  // Counter width for a count range of n values; never below one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/icestick_afifo_producer_if.sv
// AFIFO write-side bundle: generated write clock, write strobe and 12-bit pixel data.
interface icestick_afifo_producer_if;
  logic        wclk;
  logic        w;
  logic [11:0] wd;

  modport master (output wclk, output w, output wd);
  modport slave  (input  wclk, input  w, input  wd);
endinterface

// File: rtl/icestick_afifo_producer_clkdiv.sv
// Divides clk12mhz down to a 50% duty write clock and flags the cycle in which wclk is about to fall.
module producer_clkdiv
  import producer_pkg::*;
#(
  parameter int ClkDiv = 3
) (
  input  logic clk12mhz,
  input  logic rst_,
  output logic wclk_o,
  output logic beat_o
);

  localparam int CW = cnt_width(ClkDiv);

  logic [CW-1:0] count_q, count_d;
  logic          wclk_q,  wclk_d;
  logic          wrap;

  assign wrap = (count_q == CW'(ClkDiv - 1));

  always_comb begin
    count_d = count_q + CW'(1);
    wclk_d  = wclk_q;
    if (wrap) begin
      count_d = '0;
      wclk_d  = ~wclk_q;
    end
  end

  always_ff @(posedge clk12mhz or negedge rst_) begin
    if (!rst_) begin
      count_q <= '0;
      wclk_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wclk_q  <= wclk_d;
    end
  end

  assign wclk_o = wclk_q;
  assign beat_o = wrap & wclk_q;

endmodule

// File: rtl/icestick_afifo_producer.sv
// Frame/line-structured pixel source driving an AFIFO write port on a divided clock.
// Define PRODUCER_LFSR_EN to replace the incrementing data pattern with a 12-bit LFSR.
module icestick_afifo_producer
  import producer_pkg::*;
#(
  parameter int ClkDiv    = 3,
  parameter int LineWidth = 16,
  parameter int LineCount = 4,
  parameter int HBlank    = 4,
  parameter int VBlank    = 8
) (
  input  logic                       clk12mhz,
  input  logic                       rst_,
  icestick_afifo_producer_if.master  pix
);

  localparam int BEAT_MAX = (LineWidth > HBlank) ? ((LineWidth > VBlank) ? LineWidth : VBlank)
                                                 : ((HBlank > VBlank) ? HBlank : VBlank);
  localparam int BW = cnt_width(BEAT_MAX);
  localparam int LW = cnt_width(LineCount);

  localparam logic [BW-1:0] LAST_ACT  = BW'(LineWidth - 1);
  localparam logic [BW-1:0] LAST_HB   = BW'(HBlank - 1);
  localparam logic [BW-1:0] LAST_VB   = BW'(VBlank - 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(LineCount - 1);

`ifdef PRODUCER_LFSR_EN
  localparam logic [11:0] PAT_SEED = LFSR_SEED;
`else
  localparam logic [11:0] PAT_SEED = 12'd0;
`endif

  logic wclk;
  logic beat;

  producer_clkdiv #(.ClkDiv(ClkDiv)) u_clkdiv (
    .clk12mhz (clk12mhz),
    .rst_     (rst_),
    .wclk_o   (wclk),
    .beat_o   (beat)
  );

  state_e        state_q, state_d;
  logic [BW-1:0] beat_q,  beat_d;
  logic [LW-1:0] line_q,  line_d;
  logic [11:0]   pat_q,   pat_d;
  logic          w_q,     w_d;
  logic [11:0]   wd_q,    wd_d;
  logic [11:0]   pat_next;

`ifdef PRODUCER_LFSR_EN
  assign pat_next = lfsr_step(pat_q);
`else
  assign pat_next = pat_q + 12'd1;
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    line_d  = line_q;
    pat_d   = pat_q;
    w_d     = w_q;
    wd_d    = wd_q;
    if (beat) begin
      case (state_q)
        ST_ACTIVE: begin
          w_d   = 1'b1;
          wd_d  = pat_q;
          pat_d = pat_next;
          if (beat_q == LAST_ACT) begin
            beat_d  = '0;
            state_d = ST_HBLANK;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
        ST_HBLANK: begin
          w_d = 1'b0;
          if (beat_q == LAST_HB) begin
            beat_d = '0;
            if (line_q == LAST_LINE) begin
              state_d = ST_VBLANK;
            end else begin
              line_d  = line_q + LW'(1);
              state_d = ST_ACTIVE;
            end
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
        ST_VBLANK: begin
          w_d = 1'b0;
          if (beat_q == LAST_VB) begin
            // New frame: restart line count and the data pattern.
            beat_d  = '0;
            line_d  = '0;
            pat_d   = PAT_SEED;
            state_d = ST_ACTIVE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
        default: begin
          w_d     = 1'b0;
          beat_d  = '0;
          line_d  = '0;
          pat_d   = PAT_SEED;
          state_d = ST_ACTIVE;
        end
      endcase
    end
  end

  always_ff @(posedge clk12mhz or negedge rst_) begin
    if (!rst_) begin
      state_q <= ST_ACTIVE;
      beat_q  <= '0;
      line_q  <= '0;
      pat_q   <= PAT_SEED;
      w_q     <= 1'b0;
      wd_q    <= 12'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      pat_q   <= pat_d;
      w_q     <= w_d;
      wd_q    <= wd_d;
    end
  end

  assign pix.wclk = wclk;
  assign pix.w    = w_q;
  assign pix.wd   = wd_q;

endmodule

// File: tb/tb_icestick_afifo_producer.sv
// Directed bench for the pixel producer: reset, divider, line/frame timing, wrap and async reset.
module tb_icestick_afifo_producer;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  logic rst2_ = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  icestick_afifo_producer_if pix ();
  icestick_afifo_producer_if pw ();

  icestick_afifo_producer #(
    .ClkDiv(3), .LineWidth(16), .LineCount(4), .HBlank(4), .VBlank(8)
  ) dut (
    .clk12mhz (clk),
    .rst_     (rst_),
    .pix      (pix)
  );

  icestick_afifo_producer #(
    .ClkDiv(1), .LineWidth(5000), .LineCount(1), .HBlank(1), .VBlank(1)
  ) dut_wrap (
    .clk12mhz (clk),
    .rst_     (rst2_),
    .pix      (pw)
  );

  // Expected data of the k-th active beat of a frame.
  function automatic logic [11:0] exp_data(input int k);
    logic [11:0] s;
`ifdef PRODUCER_LFSR_EN
    s = 12'h001;
    for (int i = 0; i < k; i++) s = {s[10:0], s[11] ^ s[10] ^ s[9] ^ s[3]};
`else
    s = 12'(k);
`endif
    return s;
  endfunction

  // Expected outputs at the b-th beat of a default 88-beat frame.
  task automatic exp_beat(input int b, output logic ew, output logic [11:0] ewd);
    int fb, line, pos;
    fb = b % 88;
    line = fb / 20;
    pos = fb % 20;
    if (fb < 80 && pos < 16) begin
      ew = 1'b1; ewd = exp_data(line * 16 + pos);
    end else if (fb < 80) begin
      ew = 1'b0; ewd = exp_data(line * 16 + 15);
    end else begin
      ew = 1'b0; ewd = exp_data(63);
    end
  endtask

  // Waits for the next wclk rising edge of the selected instance and samples w/wd after it.
  task automatic wait_rise(input int sel, output logic w, output logic [11:0] wd, output bit ok);
    logic prev, cur;
    ok = 1'b0;
    prev = (sel == 0) ? pix.wclk : pw.wclk;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cur = (sel == 0) ? pix.wclk : pw.wclk;
      if (!prev && cur) begin
        ok = 1'b1;
        break;
      end
      prev = cur;
    end
    w  = (sel == 0) ? pix.w  : pw.w;
    wd = (sel == 0) ? pix.wd : pw.wd;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_ = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (pix.wclk !== 1'b0 || pix.w !== 1'b0 || pix.wd !== 12'd0) begin
        bad++;
        $display("FAIL reset cyc%0d: got wclk=%b w=%b wd=%h, want 0/0/000", i, pix.wclk, pix.w, pix.wd);
      end
    end
    rst_ = 1'b1;
    $display("reset released");
  endtask

  task automatic test_divider;
    int hi, lo;
    bit found;
    logic prev;
    test_reset();
    found = 1'b0;
    prev = pix.wclk;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!prev && pix.wclk) begin
        found = 1'b1;
        break;
      end
      prev = pix.wclk;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL divider_start: got no wclk rise in 20 cycles, want one");
    end
    for (int p = 0; p < 3; p++) begin
      hi = 0;
      while (pix.wclk === 1'b1 && hi < 20) begin hi++; @(negedge clk); end
      lo = 0;
      while (pix.wclk === 1'b0 && lo < 20) begin lo++; @(negedge clk); end
      $display("wclk period %0d: high=%0d low=%0d", p, hi, lo);
      total++;
      if (hi != 3 || lo != 3) begin
        bad++;
        $display("FAIL divider_p%0d: got high=%0d low=%0d, want 3/3", p, hi, lo);
      end
    end
  endtask

  // Beats [first, last] of the default stream; first edge after reset must show w=0.
  task automatic check_beats(input string name, input int first, input int last);
    logic w, ew;
    logic [11:0] wd, ewd;
    bit ok;
    for (int b = first; b <= last; b++) begin
      wait_rise(0, w, wd, ok);
      exp_beat(b, ew, ewd);
      $display("%s beat %0d: w=%b wd=%h", name, b, w, wd);
      total++;
      if (!ok || w !== ew || wd !== ewd) begin
        bad++;
        $display("FAIL %s_b%0d: got ok=%0d w=%b wd=%h, want ok=1 w=%b wd=%h", name, b, ok, w, wd, ew, ewd);
      end
    end
  endtask

  task automatic check_idle_edge(input string name);
    logic w;
    logic [11:0] wd;
    bit ok;
    wait_rise(0, w, wd, ok);
    total++;
    if (!ok || w !== 1'b0 || wd !== 12'd0) begin
      bad++;
      $display("FAIL %s_edge1: got ok=%0d w=%b wd=%h, want ok=1 w=0 wd=000", name, ok, w, wd);
    end
  endtask

  task automatic test_line;
    test_reset();
    check_idle_edge("line");
    check_beats("line", 0, 19);
  endtask

  task automatic test_frame;
    check_beats("frame", 20, 107);
  endtask

  task automatic test_async_reset;
    test_reset();
    check_idle_edge("arst");
    check_beats("arst_pre", 0, 4);
    #2;
    rst_ = 1'b0;
    #1;
    total++;
    if (pix.wclk !== 1'b0 || pix.w !== 1'b0 || pix.wd !== 12'd0) begin
      bad++;
      $display("FAIL async_clear: got wclk=%b w=%b wd=%h, want 0/0/000", pix.wclk, pix.w, pix.wd);
    end
    $display("async reset asserted mid-line: wclk=%b w=%b wd=%h", pix.wclk, pix.w, pix.wd);
    repeat (3) @(negedge clk);
    rst_ = 1'b1;
    check_idle_edge("restart");
    check_beats("restart", 0, 2);
  endtask

  task automatic test_wrap;
    logic w;
    logic [11:0] wd;
    bit ok, found;
    @(negedge clk);
    rst2_ = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4200; i++) begin
      wait_rise(1, w, wd, ok);
      if (!ok) break;
      if (w === 1'b1 && wd === 12'hFFF) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wrap_reach: got no w=1 wd=fff beat, want one");
    end
    wait_rise(1, w, wd, ok);
    $display("wrap beat after fff: w=%b wd=%h", w, wd);
    total++;
    if (!ok || w !== 1'b1 || wd !== 12'h000) begin
      bad++;
      $display("FAIL wrap_next: got ok=%0d w=%b wd=%h, want ok=1 w=1 wd=000", ok, w, wd);
    end
  endtask

  initial begin
    rst_ = 1'b0;
    rst2_ = 1'b0;
    repeat (2) @(negedge clk);
    test_divider();
    test_line();
    test_frame();
    test_async_reset();
`ifndef PRODUCER_LFSR_EN
    test_wrap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
